// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision field widths and operand layout for the align unit
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = 24;
    localparam int BIAS  = 127;
    localparam int GRS_W = 3;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

endpackage

// File: rtl/fp_rshift_sticky.sv
// rtl/fp_rshift_sticky.sv - combinational significand right shift with guard/round/sticky
// FP_ALIGN_STICKY_EN: when defined, o_grs[0] carries the sticky OR; otherwise it is tied to 0.
module fp_rshift_sticky
    import fp_pkg::*;
#(
    parameter int SIG_W   = fp_pkg::SIG_W,
    parameter int SHIFT_W = fp_pkg::EXP_W
) (
    input  logic [SIG_W-1:0]   i_sig,
    input  logic [SHIFT_W-1:0] i_shamt,
    output logic [SIG_W-1:0]   o_sig,
    output logic [GRS_W-1:0]   o_grs
);

    // Two extra low bits catch guard and round; large shifts naturally flush them to zero.
    logic [SIG_W+1:0] w_keep;
    logic             w_sticky;

    assign w_keep = {i_sig, 2'b00} >> i_shamt;

`ifdef FP_ALIGN_STICKY_EN
    // Bits below guard/round are sig[shamt-3:0]; a mask wider than SIG_W covers the whole significand.
    logic [SHIFT_W-1:0] w_lost_n;

    assign w_lost_n = (i_shamt > SHIFT_W'(2)) ? (i_shamt - SHIFT_W'(2)) : '0;
    assign w_sticky = |(i_sig & ~({SIG_W{1'b1}} << w_lost_n));
`else
    assign w_sticky = 1'b0;
`endif

    assign o_sig = w_keep[SIG_W+1:2];
    assign o_grs = {w_keep[1:0], w_sticky};

endmodule

// File: rtl/fp_align_unit.sv
// rtl/fp_align_unit.sv - two-stage FP operand compare/swap and exponent alignment pipeline
// FP_ALIGN_STICKY_EN: enables the sticky bit in grs[0] (see fp_rshift_sticky).
module fp_align_unit
    import fp_pkg::*;
#(
    parameter int EXP_W = fp_pkg::EXP_W,
    parameter int MAN_W = fp_pkg::MAN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a_op,
    input  logic [EXP_W+MAN_W:0]   b_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MAN_W:0]         sig_big,
    output logic [MAN_W:0]         sig_small,
    output logic [GRS_W-1:0]       grs,
    output logic [EXP_W-1:0]       exp_big,
    output logic                   sign_big,
    output logic                   sign_small,
    output logic                   swapped
);

    localparam int SW = MAN_W + 1;

    logic [EXP_W-1:0] w_a_exp, w_b_exp, w_a_eff, w_b_eff, w_diff;
    logic [SW-1:0]    w_a_sig, w_b_sig;
    logic             w_b_big;
    logic             w_out_load, w_s1_load;
    logic [SW-1:0]    w_sh_sig;
    logic [GRS_W-1:0] w_sh_grs;

    logic             r_s1_valid;
    logic [SW-1:0]    r_s1_sig_big, r_s1_sig_small;
    logic [EXP_W-1:0] r_s1_exp_big, r_s1_diff;
    logic             r_s1_sign_big, r_s1_sign_small, r_s1_swapped;

    logic             r_out_valid;
    logic [SW-1:0]    r_sig_big, r_sig_small;
    logic [GRS_W-1:0] r_grs;
    logic [EXP_W-1:0] r_exp_big;
    logic             r_sign_big, r_sign_small, r_swapped;

    // Denormals (stored exponent 0) have no hidden bit and sit at effective exponent 1.
    assign w_a_exp = a_op[EXP_W+MAN_W-1:MAN_W];
    assign w_b_exp = b_op[EXP_W+MAN_W-1:MAN_W];
    assign w_a_eff = (w_a_exp == '0) ? EXP_W'(1) : w_a_exp;
    assign w_b_eff = (w_b_exp == '0) ? EXP_W'(1) : w_b_exp;
    assign w_a_sig = {(w_a_exp != '0), a_op[MAN_W-1:0]};
    assign w_b_sig = {(w_b_exp != '0), b_op[MAN_W-1:0]};

    // Ties (identical magnitude) keep A as the larger operand.
    assign w_b_big = (w_b_eff > w_a_eff) || ((w_b_eff == w_a_eff) && (w_b_sig > w_a_sig));
    assign w_diff  = w_b_big ? (w_b_eff - w_a_eff) : (w_a_eff - w_b_eff);

    assign w_out_load = !r_out_valid || out_ready;
    assign w_s1_load  = !r_s1_valid || w_out_load;
    assign in_ready   = w_s1_load;

    fp_rshift_sticky #(
        .SIG_W   (SW),
        .SHIFT_W (EXP_W)
    ) u_rshift (
        .i_sig   (r_s1_sig_small),
        .i_shamt (r_s1_diff),
        .o_sig   (w_sh_sig),
        .o_grs   (w_sh_grs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid      <= 1'b0;
            r_s1_sig_big    <= '0;
            r_s1_sig_small  <= '0;
            r_s1_exp_big    <= '0;
            r_s1_diff       <= '0;
            r_s1_sign_big   <= 1'b0;
            r_s1_sign_small <= 1'b0;
            r_s1_swapped    <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sig_big    <= w_b_big ? w_b_sig : w_a_sig;
                r_s1_sig_small  <= w_b_big ? w_a_sig : w_b_sig;
                r_s1_exp_big    <= w_b_big ? w_b_eff : w_a_eff;
                r_s1_diff       <= w_diff;
                r_s1_sign_big   <= w_b_big ? b_op[EXP_W+MAN_W] : a_op[EXP_W+MAN_W];
                r_s1_sign_small <= w_b_big ? a_op[EXP_W+MAN_W] : b_op[EXP_W+MAN_W];
                r_s1_swapped    <= w_b_big;
            end
        end
    end

    // Output data only changes on an actual hand-off, so a stalled result stays put.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_sig_big    <= '0;
            r_sig_small  <= '0;
            r_grs        <= '0;
            r_exp_big    <= '0;
            r_sign_big   <= 1'b0;
            r_sign_small <= 1'b0;
            r_swapped    <= 1'b0;
        end else if (w_out_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sig_big    <= r_s1_sig_big;
                r_sig_small  <= w_sh_sig;
                r_grs        <= w_sh_grs;
                r_exp_big    <= r_s1_exp_big;
                r_sign_big   <= r_s1_sign_big;
                r_sign_small <= r_s1_sign_small;
                r_swapped    <= r_s1_swapped;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign sig_big    = r_sig_big;
    assign sig_small  = r_sig_small;
    assign grs        = r_grs;
    assign exp_big    = r_exp_big;
    assign sign_big   = r_sign_big;
    assign sign_small = r_sign_small;
    assign swapped    = r_swapped;

endmodule

// File: tb/tb_fp_align_unit.sv
// tb/tb_fp_align_unit.sv - self-checking bench: vector table, handshake sequences, random vs model
module tb_fp_align_unit;
    import fp_pkg::*;

`ifdef FP_ALIGN_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    typedef struct packed {
        logic [23:0] sig_big;
        logic [23:0] sig_small;
        logic [2:0]  grs;
        logic [7:0]  exp_big;
        logic        sign_big;
        logic        sign_small;
        logic        swapped;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        res_t        r;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a_op = '0;
    logic [31:0] b_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] sig_big, sig_small;
    logic [2:0]  grs;
    logic [7:0]  exp_big;
    logic        sign_big, sign_small, swapped;

    int n_vec = 0;
    int n_fail = 0;
    int n_drained = 0;
    res_t q[$];
    res_t got;

    assign got = {sig_big, sig_small, grs, exp_big, sign_big, sign_small, swapped};

    fp_align_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_op       (a_op),
        .b_op       (b_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sig_big    (sig_big),
        .sig_small  (sig_small),
        .grs        (grs),
        .exp_big    (exp_big),
        .sign_big   (sign_big),
        .sign_small (sign_small),
        .swapped    (swapped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference: plain integer arithmetic on the IEEE fields.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        int ea, eb, sa, sb, sm, d;
        bit b_big, g, rr, s;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sa = int'(a[22:0]) + ((ea != 0) ? (1 << 23) : 0);
        sb = int'(b[22:0]) + ((eb != 0) ? (1 << 23) : 0);
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        b_big = (eb > ea) || (eb == ea && sb > sa);
        r.swapped    = b_big;
        r.sig_big    = 24'(b_big ? sb : sa);
        r.exp_big    = 8'(b_big ? eb : ea);
        r.sign_big   = b_big ? b[31] : a[31];
        r.sign_small = b_big ? a[31] : b[31];
        sm = b_big ? sa : sb;
        d  = b_big ? (eb - ea) : (ea - eb);
        if (d >= 26) begin
            r.sig_small = '0;
            g = 0; rr = 0; s = (sm != 0);
        end else begin
            r.sig_small = 24'(sm >> d);
            g  = (d >= 1) ? bit'((sm >> (d - 1)) & 1) : 1'b0;
            rr = (d >= 2) ? bit'((sm >> (d - 2)) & 1) : 1'b0;
            s  = (d >= 3) ? ((sm % (1 << (d - 2))) != 0) : 1'b0;
        end
        if (!STICKY_EN) s = 0;
        r.grs = {g, rr, s};
        return r;
    endfunction

    function automatic res_t mask_sticky(input res_t r);
        res_t m;
        m = r;
        if (!STICKY_EN) m.grs[0] = 1'b0;
        return m;
    endfunction

    task automatic check_res(input string name, input res_t act, input res_t exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got sb=%h ss=%h grs=%b e=%h sb/ss=%b%b sw=%b, want sb=%h ss=%h grs=%b e=%h sb/ss=%b%b sw=%b",
                     name, act.sig_big, act.sig_small, act.grs, act.exp_big, act.sign_big, act.sign_small, act.swapped,
                     exp.sig_big, exp.sig_small, exp.grs, exp.exp_big, exp.sign_big, exp.sign_small, exp.swapped);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted pair is predicted; every visible result must match the head.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_result: got out_valid=1 sb=%h, want no result", sig_big);
                end else begin
                    check_res("scoreboard", got, q[0]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_drained++;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a_op, b_op));
        end
    end

    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b, input bit ordy, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        a_op      = a;
        b_op      = b;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
    endtask

    function automatic vec_t mkvec(input logic [31:0] a, input logic [31:0] b, input logic [23:0] sb,
                                   input logic [23:0] ss, input logic [2:0] g, input logic [7:0] e,
                                   input logic sgb, input logic sgs, input logic sw);
        vec_t v;
        v.a = a;
        v.b = b;
        v.r = {sb, ss, g, e, sgb, sgs, sw};
        return v;
    endfunction

    function automatic logic [31:0] rand_pair_op(input int e);
        logic [31:0] x;
        x = {1'($urandom), 8'(e), 23'($urandom)};
        return x;
    endfunction

    vec_t tbl[10];

    initial begin
        bit acc;
        int k, lat, start, ea, eb, mode, seen;
        logic [31:0] pa[3], pb[3], ra, rb;

        tbl[0] = mkvec(32'h3F800000, 32'h3F000000, 24'h800000, 24'h400000, 3'b000, 8'h7F, 0, 0, 0);
        tbl[1] = mkvec(32'h40000000, 32'h41000000, 24'h800000, 24'h200000, 3'b000, 8'h82, 0, 0, 1);
        tbl[2] = mkvec(32'h4F800000, 32'h3F800001, 24'h800000, 24'h000000, 3'b001, 8'h9F, 0, 0, 0);
        tbl[3] = mkvec(32'h00000001, 32'h00800000, 24'h800000, 24'h000001, 3'b000, 8'h01, 0, 0, 1);
        tbl[4] = mkvec(32'hC0400000, 32'hC0400000, 24'hC00000, 24'hC00000, 3'b000, 8'h80, 1, 1, 0);
        tbl[5] = mkvec(32'h3F800000, 32'h3E700005, 24'h800000, 24'h1E0000, 3'b101, 8'h7F, 0, 0, 0);
        tbl[6] = mkvec(32'h4C000000, 32'hBF800000, 24'h800000, 24'h000000, 3'b010, 8'h98, 0, 1, 0);
        tbl[7] = mkvec(32'h4C800000, 32'h3F800000, 24'h800000, 24'h000000, 3'b001, 8'h99, 0, 0, 0);
        tbl[8] = mkvec(32'h7F800000, 32'h00000000, 24'h800000, 24'h000000, 3'b000, 8'hFF, 0, 0, 0);
        tbl[9] = mkvec(32'h00400000, 32'h80600000, 24'h600000, 24'h400000, 3'b000, 8'h01, 1, 0, 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_in_ready", int'(in_ready), 1);
        check_res("reset_data", got, '0);

        // Table vectors, one at a time, with latency check
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].a, tbl[i].b, 1'b1, acc);
            check_int($sformatf("tbl%0d_accept", i), int'(acc), 1);
            lat = 0;
            seen = 0;
            while (lat < 10 && !seen) begin
                step(1'b0, '0, '0, 1'b1, acc);
                lat++;
                @(negedge clk);
                seen = int'(out_valid);
            end
            check_int($sformatf("tbl%0d_latency", i), lat, 2);
            check_res($sformatf("tbl%0d", i), got, mask_sticky(tbl[i].r));
        end

        // Backpressure: three pairs offered while the consumer stalls
        for (int i = 0; i < 3; i++) begin
            pa[i] = rand_pair_op(BIAS + i);
            pb[i] = rand_pair_op(BIAS - 3 - i);
        end
        k = 0;
        for (int c = 0; c < 4; c++) begin
            step(k < 3, pa[k % 3], pb[k % 3], 1'b0, acc);
            if (acc) k++;
        end
        check_int("bp_accepted", k, 2);
        check_int("bp_in_ready_low", int'(in_ready), 0);
        check_int("bp_out_valid", int'(out_valid), 1);
        check_res("bp_held_head", got, model(pa[0], pb[0]));
        start = n_drained;
        for (int c = 0; c < 8; c++) begin
            step(k < 3, pa[k % 3], pb[k % 3], 1'b1, acc);
            if (acc) k++;
        end
        @(negedge clk);
        check_int("bp_drained", n_drained - start, 3);
        check_int("bp_queue_empty", q.size(), 0);

        // Reset while both stages hold a pair
        step(1'b1, 32'h40400000, 32'h3F800000, 1'b0, acc);
        step(1'b1, 32'h41000000, 32'h40000000, 1'b0, acc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_in_ready", int'(in_ready), 1);
        check_res("rst_data_zero", got, '0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, '0, '0, 1'b1, acc);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_int("rst_no_ghost_results", seen, 0);

        // Random traffic with random stalls
        for (int c = 0; c < 400; c++) begin
            mode = int'($urandom_range(3));
            ea = BIAS - 10 + int'($urandom_range(20));
            case (mode)
                0: begin ra = $urandom; rb = $urandom; end
                1: begin
                    eb = ea - int'($urandom_range(30));
                    ra = rand_pair_op(ea);
                    rb = rand_pair_op(eb);
                    if ($urandom_range(1) == 1) begin ra = rb; rb = rand_pair_op(ea); end
                end
                2: begin
                    ra = rand_pair_op(0);
                    rb = rand_pair_op(int'($urandom_range(1)));
                end
                default: begin
                    ra = rand_pair_op(ea);
                    rb = ($urandom_range(3) == 0) ? ra : rand_pair_op(ea);
                end
            endcase
            step($urandom_range(3) != 0, ra, rb, $urandom_range(3) != 0, acc);
        end
        for (int c = 0; c < 10; c++) step(1'b0, '0, '0, 1'b1, acc);
        @(negedge clk);
        check_int("random_drain_empty", q.size(), 0);
        check_int("random_out_idle", int'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
